// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_MDU = 2'd1
    } state_e;

    localparam int STALL_PC     = 0;
    localparam int STALL_IFID   = 1;
    localparam int STALL_IDEXE  = 2;
    localparam int STALL_EXEMEM = 3;
    localparam int STALL_MEMWB  = 4;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    // Front hold freezes pc and if_id; the bus wait freezes everything up to exe_mem.
    localparam logic [4:0] STALL_FRONT = (5'b1 << STALL_PC) | (5'b1 << STALL_IFID);
    localparam logic [4:0] STALL_MEMW  = STALL_FRONT | (5'b1 << STALL_IDEXE) | (5'b1 << STALL_EXEMEM);

    function automatic logic src_hit(input logic re, input logic [4:0] src, input logic [4:0] dst);
        return re && (src == dst) && (dst != NOP_REG_ADDR);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign at_max = &q_q;
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !at_max) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush control: load-use detection, MDU sequencing and bus-wait freeze.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int MEMW_MAX    = 1024,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_re,
    input  logic             id_rt_re,
    input  logic             id_mdu_start,
    input  logic [4:0]       exe_write_reg,
    input  logic             exe_we,
    input  logic             exe_is_load,
    input  logic             mdu_done,
    input  logic             mem_wait,
    output logic [4:0]       stall,
    output logic             flush_id_exe,
    output logic             flush_mem_wb,
    output logic             mdu_go,
    output logic             err_mdu_to,
    output logic             err_mem_to,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDU_W  = $clog2(MDU_TIMEOUT) + 1;
    localparam int MEMW_W = $clog2(MEMW_MAX) + 1;

    state_e            state_q, state_d;
    logic              done_seen_q, done_seen_d;
    logic              err_mdu_q, err_mdu_d;
    logic              err_mem_q, err_mem_d;
    logic              load_use, mdu_expired, mdu_fin;
    logic              mdu_clr, mdu_inc, stall_inc;
    logic [MDU_W-1:0]  mdu_cnt;
    logic [MEMW_W-1:0] memw_cnt;
    logic              unused_mdu_max, unused_memw_max, unused_stall_max;

    assign load_use = exe_is_load && exe_we &&
                      (src_hit(id_rs_re, id_rs_addr, exe_write_reg) ||
                       src_hit(id_rt_re, id_rt_addr, exe_write_reg));
    assign mdu_expired = (mdu_cnt == MDU_W'(MDU_TIMEOUT - 1));
    assign mdu_fin     = mdu_done || done_seen_q || mdu_expired;
    assign mdu_clr     = (state_q != S_MDU);
    assign stall_inc   = (|stall) || flush_id_exe || flush_mem_wb;

    always_comb begin
        stall        = '0;
        flush_id_exe = 1'b0;
        flush_mem_wb = 1'b0;
        mdu_go       = 1'b0;
        mdu_inc      = 1'b0;
        state_d      = state_q;
        done_seen_d  = done_seen_q;
        err_mdu_d    = err_mdu_q;
        err_mem_d    = err_mem_q;
        if (mem_wait) begin
            stall        = STALL_MEMW;
            flush_mem_wb = 1'b1;
            if (state_q == S_MDU && mdu_done) begin
                done_seen_d = 1'b1;
            end
            if (memw_cnt >= MEMW_W'(MEMW_MAX - 1)) begin
                err_mem_d = 1'b1;
            end
        end else if (state_q == S_MDU) begin
            // Releasing the hold in the done cycle lets the mult/div advance into id_exe.
            if (mdu_fin) begin
                state_d     = S_RUN;
                done_seen_d = 1'b0;
                if (!(mdu_done || done_seen_q)) begin
                    err_mdu_d = 1'b1;
                end
            end else begin
                stall        = STALL_FRONT;
                flush_id_exe = 1'b1;
                mdu_inc      = 1'b1;
            end
        end else if (load_use) begin
            stall        = STALL_FRONT;
            flush_id_exe = 1'b1;
        end else if (id_mdu_start) begin
            stall        = STALL_FRONT;
            flush_id_exe = 1'b1;
            mdu_go       = 1'b1;
            state_d      = S_MDU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            done_seen_q <= 1'b0;
            err_mdu_q   <= 1'b0;
            err_mem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            err_mdu_q   <= err_mdu_d;
            err_mem_q   <= err_mem_d;
        end
    end

    assign err_mdu_to = err_mdu_q;
    assign err_mem_to = err_mem_q;

    sat_counter #(.W(MDU_W)) u_mdu_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mdu_clr),
        .inc    (mdu_inc),
        .q      (mdu_cnt),
        .at_max (unused_mdu_max)
    );

    sat_counter #(.W(MEMW_W)) u_memw_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!mem_wait),
        .inc    (mem_wait),
        .q      (memw_cnt),
        .at_max (unused_memw_max)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (stall_inc),
        .q      (stall_cycles),
        .at_max (unused_stall_max)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with shortened timeouts and a 4-bit stall counter.
module tb_hazard_stall_ctrl;

    localparam int CW = 4;
    localparam int VW = 10 + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs_addr, id_rt_addr, exe_write_reg;
    logic          id_rs_re, id_rt_re, id_mdu_start, exe_we, exe_is_load, mdu_done, mem_wait;
    logic [4:0]    stall;
    logic          flush_id_exe, flush_mem_wb, mdu_go, err_mdu_to, err_mem_to;
    logic [CW-1:0] stall_cycles;

    typedef struct {
        int            id;
        logic [VW-1:0] v;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            step_id = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_emdu = 1'b0;
    logic          exp_emem = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_TIMEOUT(16), .MEMW_MAX(8), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rs_re      (id_rs_re),
        .id_rt_re      (id_rt_re),
        .id_mdu_start  (id_mdu_start),
        .exe_write_reg (exe_write_reg),
        .exe_we        (exe_we),
        .exe_is_load   (exe_is_load),
        .mdu_done      (mdu_done),
        .mem_wait      (mem_wait),
        .stall         (stall),
        .flush_id_exe  (flush_id_exe),
        .flush_mem_wb  (flush_mem_wb),
        .mdu_go        (mdu_go),
        .err_mdu_to    (err_mdu_to),
        .err_mem_to    (err_mem_to),
        .stall_cycles  (stall_cycles)
    );

    task automatic idle();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_re = 1'b0; id_rt_re = 1'b0;
        id_mdu_start = 1'b0; exe_write_reg = 5'd0; exe_we = 1'b0; exe_is_load = 1'b0;
        mdu_done = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic exe(input logic [4:0] wr, input logic ld);
        exe_write_reg = wr; exe_we = 1'b1; exe_is_load = ld;
    endtask

    task automatic idr(input logic [4:0] rs, input logic rsre, input logic [4:0] rt, input logic rtre);
        id_rs_addr = rs; id_rs_re = rsre; id_rt_addr = rt; id_rt_re = rtre;
    endtask

    // Expected stall_cycles is the number of earlier stall cycles, held at all-ones.
    task automatic expect_out(input logic [4:0] s, input logic fid, input logic fmw, input logic go);
        exp_t e;
        e.id = step_id;
        e.v  = {s, fid, fmw, go, exp_emdu, exp_emem, exp_cnt};
        sb.push_back(e);
        step_id++;
        if ((|s || fid || fmw) && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [VW-1:0] act;
            e   = sb.pop_front();
            act = {stall, flush_id_exe, flush_mem_wb, mdu_go, err_mdu_to, err_mem_to, stall_cycles};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL step%0d {stall,fid,fmw,go,emdu,emem,cnt} got %b expected %b", e.id, act, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        cyc(); rst_n = 1'b1; expect_out(5'b00000, 0, 0, 0);

        // load-use and its non-hazard variants
        cyc(); exe(5'd5, 1); idr(5'd5, 1, 5'd0, 0); expect_out(5'b00011, 1, 0, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);
        cyc(); exe(5'd0, 1); idr(5'd0, 1, 5'd0, 1); expect_out(5'b00000, 0, 0, 0);
        cyc(); exe(5'd5, 1); idr(5'd0, 0, 5'd5, 0); expect_out(5'b00000, 0, 0, 0);
        cyc(); exe(5'd5, 1); idr(5'd0, 0, 5'd5, 1); expect_out(5'b00011, 1, 0, 0);
        cyc(); exe(5'd5, 0); idr(5'd5, 1, 5'd5, 1); expect_out(5'b00000, 0, 0, 0);

        // MDU done 10 cycles after start
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 0);
        end
        cyc(); id_mdu_start = 1'b1; mdu_done = 1'b1; expect_out(5'b00000, 0, 0, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);
        cyc(); mdu_done = 1'b1; expect_out(5'b00000, 0, 0, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);

        // done arrives during a bus wait and is consumed afterwards
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        cyc(); expect_out(5'b00011, 1, 0, 0);
        cyc(); mem_wait = 1'b1; expect_out(5'b01111, 0, 1, 0);
        cyc(); mem_wait = 1'b1; mdu_done = 1'b1; expect_out(5'b01111, 0, 1, 0);
        cyc(); mem_wait = 1'b1; expect_out(5'b01111, 0, 1, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);

        // priority: mem_wait over load-use, load-use over MDU start
        cyc(); exe(5'd7, 1); idr(5'd7, 1, 5'd0, 0); mem_wait = 1'b1; expect_out(5'b01111, 0, 1, 0);
        cyc(); exe(5'd7, 1); idr(5'd7, 1, 5'd0, 0); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 0);
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        cyc(); mdu_done = 1'b1; expect_out(5'b00000, 0, 0, 0);

        // MDU never completes
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            cyc(); expect_out(5'b00011, 1, 0, 0);
        end
        cyc(); expect_out(5'b00000, 0, 0, 0);
        exp_emdu = 1'b1;
        cyc(); expect_out(5'b00000, 0, 0, 0);

        // bus wait reaching the limit
        for (int i = 1; i <= 8; i++) begin
            cyc(); mem_wait = 1'b1; expect_out(5'b01111, 0, 1, 0);
        end
        exp_emem = 1'b1;
        cyc(); expect_out(5'b00000, 0, 0, 0);

        // asynchronous reset in the middle of an MDU wait
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        cyc(); expect_out(5'b00011, 1, 0, 0);
        cyc(); rst_n = 1'b0; exp_cnt = '0; exp_emdu = 1'b0; exp_emem = 1'b0;
        expect_out(5'b00000, 0, 0, 0);
        cyc(); rst_n = 1'b1; expect_out(5'b00000, 0, 0, 0);
        cyc(); id_mdu_start = 1'b1; expect_out(5'b00011, 1, 0, 1);
        cyc(); mdu_done = 1'b1; expect_out(5'b00000, 0, 0, 0);
        cyc(); expect_out(5'b00000, 0, 0, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
